// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one decoder-selected resource.
// A 2-bit winner index is expanded to a registered one-hot grant; ownership has a hold limit.
module decoder_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic [3:0] done,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e           state_q, state_d;
   logic [3:0]       gnt_q, gnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;

   logic             found;
   logic [1:0]       winner;
   logic [1:0]       cand;

   function automatic logic [3:0] decode2to4(input logic [1:0] idx);
      logic [3:0] oh;
      oh      = 4'b0000;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   // Search starts one past the last owner; offset 4 wraps back to the last owner itself.
   always_comb begin
      found  = 1'b0;
      winner = idx_q;
      cand   = idx_q;
      for (int i = 1; i <= 4; i++) begin
         cand = idx_q + 2'(i);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         StIdle: begin
            gnt_d = 4'b0000;
            if (found) begin
               state_d = StGrant;
               idx_d   = winner;
               gnt_d   = decode2to4(winner);
               cnt_d   = CNT_W'(1);
            end
         end
         StGrant: begin
            // Normal release outranks the hold limit, so done on the last cycle never times out.
            if (!req[idx_q] || done[idx_q]) begin
               state_d = StIdle;
               gnt_d   = 4'b0000;
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
               state_d   = StIdle;
               gnt_d     = 4'b0000;
               cnt_d     = '0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         gnt_q     <= 4'b0000;
         idx_q     <= 2'b11;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = (state_q == StGrant);
   assign timeout   = timeout_q;

endmodule
